// File: rtl/rv64g_l2_line_xfer.sv
// L2 line-transfer sequencer: refill beats into the data/tag arrays,
// and victim lines out of them as a registered valid/ready beat stream.
module rv64g_l2_line_xfer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [7:0]  cmd_index_i,
  input  logic [3:0]  cmd_way_i,
  input  logic [49:0] cmd_tag_i,
  input  logic        fill_valid_i,
  output logic        fill_ready_o,
  input  logic [63:0] fill_data_i,
  output logic        ev_valid_o,
  input  logic        ev_ready_i,
  output logic [63:0] ev_data_o,
  output logic        ev_last_o,
  output logic        done_o,
  output logic        busy_o,
  output logic [7:0]  arr_index_o,
  output logic [2:0]  arr_word_o,
  output logic [3:0]  arr_way_o,
  output logic        arr_data_we_o,
  output logic        arr_tag_we_o,
  output logic [7:0]  arr_be_o,
  output logic [63:0] arr_wdata_o,
  output logic [49:0] arr_tag_o,
  input  logic [63:0] arr_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FILL_TAG,
    S_EVICT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [3:0]  way_q, way_d;
  logic [49:0] tag_q, tag_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic        ev_valid_q, ev_valid_d;
  logic [63:0] ev_data_q, ev_data_d;

  logic st_idle, st_fill, st_tag, st_evict;
  logic pop, capture;

  assign st_idle  = (state_q == S_IDLE);
  assign st_fill  = (state_q == S_FILL);
  assign st_tag   = (state_q == S_FILL_TAG);
  assign st_evict = (state_q == S_EVICT);

  assign pop     = ev_valid_q & ev_ready_i;
  // Output register refills while empty or being drained this cycle.
  assign capture = st_evict & ~rd_cnt_q[3] & (~ev_valid_q | ev_ready_i);

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    way_d      = way_q;
    tag_d      = tag_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    ev_valid_d = ev_valid_q;
    ev_data_d  = ev_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          index_d   = cmd_index_i;
          way_d     = cmd_way_i;
          tag_d     = cmd_tag_i;
          wr_cnt_d  = 3'd0;
          rd_cnt_d  = 4'd0;
          out_cnt_d = 3'd0;
          state_d   = cmd_op_i ? S_EVICT : S_FILL;
        end
      end
      S_FILL: begin
        if (fill_valid_i) begin
          wr_cnt_d = wr_cnt_q + 3'd1;
          if (wr_cnt_q == 3'd7) state_d = S_FILL_TAG;
        end
      end
      S_FILL_TAG: begin
        state_d = S_IDLE;
      end
      S_EVICT: begin
        if (capture) begin
          ev_data_d  = arr_rdata_i;
          rd_cnt_d   = rd_cnt_q + 4'd1;
          ev_valid_d = 1'b1;
        end else if (pop) begin
          ev_valid_d = 1'b0;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      way_q      <= way_d;
      tag_q      <= tag_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
    end
  end

  assign cmd_ready_o   = st_idle;
  assign busy_o        = ~st_idle;
  assign fill_ready_o  = st_fill;
  assign ev_valid_o    = ev_valid_q;
  assign ev_data_o     = ev_data_q;
  assign ev_last_o     = ev_valid_q & (out_cnt_q == 3'd7);
  assign done_o        = st_tag | (st_evict & pop & (out_cnt_q == 3'd7));
  assign arr_index_o   = index_q;
  assign arr_way_o     = way_q;
  assign arr_tag_o     = tag_q;
  assign arr_word_o    = st_evict ? rd_cnt_q[2:0] : wr_cnt_q;
  assign arr_data_we_o = st_fill & fill_valid_i;
  assign arr_tag_we_o  = st_tag;
  assign arr_be_o      = {8{arr_data_we_o}};
  assign arr_wdata_o   = fill_data_i;

endmodule
